// File: rtl/wts_slot_pkg.sv
// Shared types and defaults for the MSX slot bus initiator.
package wts_slot_pkg;
  localparam int T_STATE_CLKS_DEF = 6;
  localparam int WAIT_STATES_DEF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3
  } slot_state_t;
endpackage

// File: rtl/wts_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module wts_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/wts_slot_initiator.sv
// MSX slot bus initiator: req/done handshake to Z80-timed memory cycles.
// state | meaning
// IDLE  | ready for a request, slot_a holds last address
// T1    | address out; strobes and write data asserted at mid-state
// T2    | write strobe asserted
// TW    | wait states, strobes hold
// T3    | read sample, strobes released at mid-state, data hold to end
module wts_slot_initiator
  import wts_slot_pkg::*;
#(
  parameter int T_STATE_CLKS = T_STATE_CLKS_DEF,
  parameter int WAIT_STATES  = WAIT_STATES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_d,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        irq,
  output logic        slot_nreset,
  output logic [15:0] slot_a,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic [7:0]  slot_d_in,
  output logic        slot_nsltsl,
  output logic        slot_nmerq,
  output logic        slot_nrd,
  output logic        slot_nwr,
  input  logic        slot_nint
);
  localparam int CW = $clog2(T_STATE_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_STATE_CLKS - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(T_STATE_CLKS / 2);
  localparam logic [CW-1:0] CNT_HM1  = CW'(T_STATE_CLKS / 2 - 1);
  localparam logic [1:0]    W_LAST   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  slot_state_t   state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [1:0]    wcnt, nwcnt;
  logic          accept;
  logic          lat_wr;
  logic [7:0]    lat_d;
  logic          bus_act, wr_act, oe_act;

  always_comb begin
    nstate = state;
    ncnt   = cnt + 1'b1;
    nwcnt  = wcnt;
    accept = 1'b0;
    case (state)
      ST_IDLE: begin
        ncnt = '0;
        if (req && ready) begin
          nstate = ST_T1;
          accept = 1'b1;
        end
      end
      ST_T1: if (cnt == CNT_LAST) begin
        ncnt   = '0;
        nstate = ST_T2;
      end
      ST_T2: if (cnt == CNT_LAST) begin
        ncnt = '0;
        if (WAIT_STATES > 0) begin
          nstate = ST_TW;
          nwcnt  = 2'd0;
        end else begin
          nstate = ST_T3;
        end
      end
      ST_TW: if (cnt == CNT_LAST) begin
        ncnt = '0;
        if (wcnt == W_LAST) nstate = ST_T3;
        else nwcnt = wcnt + 2'd1;
      end
      ST_T3: if (cnt == CNT_LAST) begin
        ncnt   = '0;
        nstate = ST_IDLE;
      end
      default: begin
        ncnt   = '0;
        nstate = ST_IDLE;
      end
    endcase
  end

  // Strobe levels are decoded from the upcoming state so every pin is a flop.
  always_comb begin
    bus_act = ((nstate == ST_T1) && (ncnt >= CNT_H)) || (nstate == ST_T2) ||
              (nstate == ST_TW) || ((nstate == ST_T3) && (ncnt < CNT_H));
    wr_act  = lat_wr && ((nstate == ST_T2) || (nstate == ST_TW) ||
              ((nstate == ST_T3) && (ncnt < CNT_H)));
    oe_act  = lat_wr && (((nstate == ST_T1) && (ncnt >= CNT_H)) || (nstate == ST_T2) ||
              (nstate == ST_TW) || (nstate == ST_T3));
  end

  always_ff @(posedge clk) begin
    slot_nreset <= ~reset;
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wcnt        <= 2'd0;
      lat_wr      <= 1'b0;
      lat_d       <= 8'h00;
      ready       <= 1'b1;
      done        <= 1'b0;
      rdata       <= 8'h00;
      slot_a      <= 16'h0000;
      slot_d_out  <= 8'h00;
      slot_d_oe   <= 1'b0;
      slot_nsltsl <= 1'b1;
      slot_nmerq  <= 1'b1;
      slot_nrd    <= 1'b1;
      slot_nwr    <= 1'b1;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      wcnt        <= nwcnt;
      ready       <= (nstate == ST_IDLE);
      done        <= (state == ST_T3) && (cnt == CNT_LAST);
      slot_nsltsl <= ~bus_act;
      slot_nmerq  <= ~bus_act;
      slot_nrd    <= ~(bus_act && !lat_wr);
      slot_nwr    <= ~wr_act;
      slot_d_oe   <= oe_act;
      if (accept) begin
        lat_wr <= req_wr;
        lat_d  <= req_d;
        slot_a <= req_a;
      end
      if (lat_wr && (nstate == ST_T1) && (ncnt == CNT_H)) slot_d_out <= lat_d;
      if (!lat_wr && (state == ST_T3) && (cnt == CNT_HM1)) rdata <= slot_d_in;
    end
  end

  wts_sync2 #(.RST_VAL(1'b0)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~slot_nint),
    .q     (irq)
  );
endmodule

// File: tb/tb_wts_slot_initiator.sv
// Self-checking bench: one initiator with no wait states, one with a single wait state.
module tb_wts_slot_initiator;
  localparam int T = 6;
  localparam int H = T / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req_wr = 1'b0;
  logic [15:0] req_a = 16'h0;
  logic [7:0]  req_d = 8'h0;
  logic [7:0]  slot_d_in = 8'h0;
  logic        slot_nint = 1'b1;
  logic        sel = 1'b0;

  logic [1:0]        ready_v, done_v, irq_v, nreset_v, oe_v, nsltsl_v, nmerq_v, nrd_v, nwr_v;
  logic [1:0][7:0]   rdata_v, dout_v;
  logic [1:0][15:0]  a_v;

  logic        o_ready, o_done, o_irq, o_nreset, o_oe, o_nsltsl, o_nmerq, o_nrd, o_nwr;
  logic [7:0]  o_rdata, o_dout;
  logic [15:0] o_a;

  int          n_cmp = 0, n_fail = 0;
  logic [7:0]  exp_rd [2];

  always #5 clk = ~clk;

  wts_slot_initiator #(.T_STATE_CLKS(T), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req && !sel), .req_wr(req_wr), .req_a(req_a), .req_d(req_d),
    .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .irq(irq_v[0]),
    .slot_nreset(nreset_v[0]), .slot_a(a_v[0]), .slot_d_out(dout_v[0]), .slot_d_oe(oe_v[0]),
    .slot_d_in(slot_d_in), .slot_nsltsl(nsltsl_v[0]), .slot_nmerq(nmerq_v[0]),
    .slot_nrd(nrd_v[0]), .slot_nwr(nwr_v[0]), .slot_nint(slot_nint));

  wts_slot_initiator #(.T_STATE_CLKS(T), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req && sel), .req_wr(req_wr), .req_a(req_a), .req_d(req_d),
    .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .irq(irq_v[1]),
    .slot_nreset(nreset_v[1]), .slot_a(a_v[1]), .slot_d_out(dout_v[1]), .slot_d_oe(oe_v[1]),
    .slot_d_in(slot_d_in), .slot_nsltsl(nsltsl_v[1]), .slot_nmerq(nmerq_v[1]),
    .slot_nrd(nrd_v[1]), .slot_nwr(nwr_v[1]), .slot_nint(slot_nint));

  always_comb begin
    o_ready  = ready_v[sel];
    o_done   = done_v[sel];
    o_irq    = irq_v[sel];
    o_nreset = nreset_v[sel];
    o_oe     = oe_v[sel];
    o_nsltsl = nsltsl_v[sel];
    o_nmerq  = nmerq_v[sel];
    o_nrd    = nrd_v[sel];
    o_nwr    = nwr_v[sel];
    o_rdata  = rdata_v[sel];
    o_dout   = dout_v[sel];
    o_a      = a_v[sel];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_nsltsl"}, 32'(o_nsltsl), 32'd1);
    chk({tag, "_nmerq"},  32'(o_nmerq),  32'd1);
    chk({tag, "_nrd"},    32'(o_nrd),    32'd1);
    chk({tag, "_nwr"},    32'(o_nwr),    32'd1);
    chk({tag, "_oe"},     32'(o_oe),     32'd0);
  endtask

  // Expected pin behaviour is taken from the clk-indexed strobe windows.
  task automatic do_txn(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] rsp, input bit hold);
    int w, len, lo_end, guard;
    w      = sel ? 1 : 0;
    len    = (3 + w) * T;
    lo_end = len - T + H - 1;
    guard  = 0;
    while (o_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(o_ready), 32'd1);
    req = 1'b1; req_wr = wr; req_a = a; req_d = d;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    if (!wr) exp_rd[sel] = rsp;
    for (int k = 0; k <= len; k++) begin
      bit act, oe_exp;
      @(negedge clk);
      act    = (k >= H) && (k <= lo_end);
      oe_exp = wr && (k >= H) && (k <= len - 1);
      chk("nsltsl", 32'(o_nsltsl), 32'(!act));
      chk("nmerq",  32'(o_nmerq),  32'(!act));
      chk("nrd",    32'(o_nrd),    32'(!(act && !wr)));
      chk("nwr",    32'(o_nwr),    32'(!(wr && k >= T && k <= lo_end)));
      chk("oe",     32'(o_oe),     32'(oe_exp));
      if (oe_exp) chk("d_out", 32'(o_dout), 32'(d));
      chk("slot_a", 32'(o_a),      32'(a));
      chk("done",   32'(o_done),   32'(k == len));
      chk("ready",  32'(o_ready),  32'(k == len));
      chk("nreset", 32'(o_nreset), 32'd1);
      if (k == len) chk("rdata", 32'(o_rdata), 32'(exp_rd[sel]));
      slot_d_in = (o_nrd == 1'b0) ? rsp : 8'($urandom);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rsp;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 16'h4000, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 16'h7FFE, 8'h3C, 8'h11, 8'hA5};
    vecs[2] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 16'hFFFF, 8'h00, 8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 16'hFFFF, 8'hFF, 8'h22, 8'hFF};
    vecs[5] = '{1'b1, 16'h0000, 8'h00, 8'h33, 8'hFF};
    vecs[6] = '{1'b0, 16'h1234, 8'h00, 8'h5A, 8'h5A};
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;

    // reset held for 3 clks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_pins("rst");
      chk("rst_ready",  32'(o_ready),  32'd1);
      chk("rst_rdata",  32'(o_rdata),  32'd0);
      chk("rst_irq",    32'(o_irq),    32'd0);
      chk("rst_nreset", 32'(o_nreset), 32'd0);
      chk("rst_done",   32'(o_done),   32'd0);
      chk("rst_a",      32'(o_a),      32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("nreset_rel", 32'(o_nreset), 32'd1);
    chk_idle_pins("post_rst");

    // table vectors, applied back to back on the no-wait initiator
    sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rsp, 1'b0);
      chk("vec_rdata", 32'(o_rdata), 32'(vecs[i].exp_rdata));
    end
    @(negedge clk);
    chk("slot_a_hold", 32'(o_a), 32'h1234);

    // one wait state; req held through busy, second req accepted in the done cycle
    sel = 1'b1;
    do_txn(1'b0, 16'h8000, 8'h00, 8'h96, 1'b1);
    do_txn(1'b0, 16'h8000, 8'h00, 8'h69, 1'b0);
    @(negedge clk);
    chk("w1_idle_done", 32'(o_done), 32'd0);

    // reset at clk 8 of a write
    sel = 1'b0;
    req = 1'b1; req_wr = 1'b1; req_a = 16'h2000; req_d = 8'h55;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_nwr", 32'(o_nwr), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_pins("abort");
    chk("abort_done",   32'(o_done),   32'd0);
    chk("abort_ready",  32'(o_ready),  32'd1);
    chk("abort_a",      32'(o_a),      32'd0);
    chk("abort_dout",   32'(o_dout),   32'd0);
    chk("abort_nreset", 32'(o_nreset), 32'd0);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(o_done),  32'd0);
      chk("abort_nmerq",   32'(o_nmerq), 32'd1);
    end
    do_txn(1'b0, 16'h2001, 8'h00, 8'hC3, 1'b0);

    // interrupt synchronizer
    slot_nint = 1'b0;
    @(negedge clk); chk("irq_lat1", 32'(o_irq), 32'd0);
    @(negedge clk); chk("irq_rise", 32'(o_irq), 32'd1);
    repeat (8) begin
      @(negedge clk); chk("irq_hold", 32'(o_irq), 32'd1);
    end
    slot_nint = 1'b1;
    @(negedge clk); chk("irq_lat2", 32'(o_irq), 32'd1);
    @(negedge clk); chk("irq_fall", 32'(o_irq), 32'd0);

    // randomized traffic across both initiators
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      sel = 1'($urandom_range(0, 1));
      do_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end
    @(negedge clk);
    chk("final_rd0", 32'(rdata_v[0]), 32'(exp_rd[0]));
    chk("final_rd1", 32'(rdata_v[1]), 32'(exp_rd[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
